fifo_rd_packer: RTL

Read-side consumer for the byte-wide async FIFO, in the clkb domain. It pops bytes from the FIFO read port (rd/empty/dout_clkb) and packs BYTES consecutive bytes into one word. Each word goes out on a valid/ready interface with a one-word output holding register, so assembly of the next word continues under backpressure. It is the stage directly downstream of the FIFO; nothing else drives the FIFO `rd`.

---
 rtl/packer_pkg.sv | 21 ++
 rtl/packer_out_stage.sv | 37 +++
 rtl/fifo_rd_packer.sv | 118 +++++++++++
 3 files changed

// File: rtl/packer_pkg.sv
// Shared widths and types for the FIFO read-side byte packer.
// The optional flush feature is enabled with PACKER_FLUSH_EN.
package packer_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_BYTES  = 4;
   localparam int DEF_WORD_W = DEF_DATA_W * DEF_BYTES;
   localparam int DEF_CNT_W  = $clog2(DEF_BYTES) + 1;

   typedef logic [DEF_DATA_W-1:0] pk_byte_t;
   typedef logic [DEF_WORD_W-1:0] pk_word_t;
   typedef logic [DEF_CNT_W-1:0]  pk_cnt_t;

   // Where a word entering the output register comes from this cycle.
   typedef enum logic [1:0] {
      LOAD_NONE,
      LOAD_DIRECT,
      LOAD_ASM
   } load_src_e;

endpackage

// File: rtl/packer_out_stage.sv
// One-word valid/ready holding register; knows nothing about the FIFO.
module packer_out_stage
   import packer_pkg::*;
#(
   parameter int WORD_W = DEF_WORD_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic              clkb,
   input  logic              resetb_clkb,
   input  logic              load,
   input  logic [WORD_W-1:0] load_data,
   input  logic [CNT_W-1:0]  load_bytes,
   input  logic              word_ready,
   output logic              word_valid,
   output logic [WORD_W-1:0] word_data,
   output logic [CNT_W-1:0]  word_bytes,
   output logic              free
);

   // Free when empty, or when the held word drains at this edge.
   assign free = !word_valid || word_ready;

   always_ff @(posedge clkb or negedge resetb_clkb) begin
      if (!resetb_clkb) begin
         word_valid <= 1'b0;
         word_data  <= '0;
         word_bytes <= '0;
      end else if (load) begin
         word_valid <= 1'b1;
         word_data  <= load_data;
         word_bytes <= load_bytes;
      end else if (word_valid && word_ready) begin
         word_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/fifo_rd_packer.sv
// Pops bytes from the async FIFO read port and packs BYTES of them per output word.
// Define PACKER_FLUSH_EN to add the flush input for emitting partial words.
module fifo_rd_packer
   import packer_pkg::*;
#(
   parameter  int DATA_W = DEF_DATA_W,
   parameter  int BYTES  = DEF_BYTES,
   localparam int WORD_W = DATA_W * BYTES,
   localparam int CNT_W  = $clog2(BYTES) + 1
) (
   input  logic              clkb,
   input  logic              resetb_clkb,
   input  logic              empty,
   output logic              rd,
   input  logic [DATA_W-1:0] dout_clkb,
   output logic              word_valid,
   input  logic              word_ready,
   output logic [WORD_W-1:0] word_data,
   output logic [CNT_W-1:0]  word_bytes
`ifdef PACKER_FLUSH_EN
   ,
   input  logic              flush
`endif
);

   localparam logic [CNT_W-1:0] FULL = CNT_W'(BYTES);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(BYTES - 1);

   logic [CNT_W-1:0]  cnt;
   logic              pend;
   logic              flush_req;
   logic [DATA_W-1:0] asm_buf [BYTES];
   logic [CNT_W:0]    in_flight;
   logic              out_free;
   logic              load;
   logic [WORD_W-1:0] load_data;
   logic [CNT_W-1:0]  load_bytes;
   load_src_e         load_src;

   // Never pop more than the assembly buffer can take, counting the byte in flight.
   assign in_flight = {1'b0, cnt} + (CNT_W+1)'(pend);
   assign rd = resetb_clkb && !empty && (in_flight < (CNT_W+1)'(BYTES)) && !flush_req;

   // A full or flushed buffer moves out only once no byte is still landing.
   always_comb begin
      load_src = LOAD_NONE;
      if (pend && cnt == LAST && out_free) begin
         load_src = LOAD_DIRECT;
      end else if (!pend && out_free && (cnt == FULL || (flush_req && cnt != '0))) begin
         load_src = LOAD_ASM;
      end
   end

   assign load = (load_src != LOAD_NONE);

   // Lanes at or above cnt are stale leftovers and must read as zero.
   always_comb begin
      load_data = '0;
      for (int i = 0; i < BYTES; i++) begin
         if (CNT_W'(i) < cnt) begin
            load_data[i*DATA_W +: DATA_W] = asm_buf[i];
         end
      end
      if (load_src == LOAD_DIRECT) begin
         load_data[WORD_W-1 -: DATA_W] = dout_clkb;
      end
      load_bytes = (load_src == LOAD_DIRECT) ? FULL : cnt;
   end

   always_ff @(posedge clkb or negedge resetb_clkb) begin
      if (!resetb_clkb) begin
         cnt  <= '0;
         pend <= 1'b0;
         for (int i = 0; i < BYTES; i++) begin
            asm_buf[i] <= '0;
         end
      end else begin
         pend <= rd;
         if (load) begin
            cnt <= '0;
         end else if (pend) begin
            asm_buf[cnt[CNT_W-2:0]] <= dout_clkb;
            cnt                     <= cnt + 1'b1;
         end
      end
   end

`ifdef PACKER_FLUSH_EN
   always_ff @(posedge clkb or negedge resetb_clkb) begin
      if (!resetb_clkb) begin
         flush_req <= 1'b0;
      end else if (flush) begin
         flush_req <= 1'b1;
      end else if (flush_req && !pend && (cnt == '0 || load_src == LOAD_ASM)) begin
         flush_req <= 1'b0;
      end
   end
`else
   assign flush_req = 1'b0;
`endif

   packer_out_stage #(
      .WORD_W (WORD_W),
      .CNT_W  (CNT_W)
   ) u_out (
      .clkb        (clkb),
      .resetb_clkb (resetb_clkb),
      .load        (load),
      .load_data   (load_data),
      .load_bytes  (load_bytes),
      .word_ready  (word_ready),
      .word_valid  (word_valid),
      .word_data   (word_data),
      .word_bytes  (word_bytes),
      .free        (out_free)
   );

endmodule
